// File: rtl/mem_fill.sv
// mem_fill: range fill engine for a single-port RAM, one word per cycle.
// Patterns: identity, constant, complement, xor with fill_val.
// Define MEM_FILL_VERIFY_EN to build the read-back verify pass (READ/CHECK) and a sticky err flag.
// Without the macro, rddata is ignored and err is tied low.
module mem_fill #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] lo_addr,
    input  logic [ADDR_W-1:0] hi_addr,
    input  logic [DATA_W-1:0] fill_val,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
    input  logic [DATA_W-1:0] rddata,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_CHECK} state_t;

    // The cursor has one extra bit so hi_addr = all-ones ends the range without wrapping to 0.
    localparam logic [ADDR_W:0] CUR_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] fv_q, fv_d;
    logic [ADDR_W:0]   cur_q, cur_d;
    logic              rdy_q, rdy_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic              cur_past_hi;

`ifdef MEM_FILL_VERIFY_EN
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic              err_q, err_d;
    logic              rd_pend_q, rd_pend_d;  // addr_q holds a read address this cycle
    logic              cmp_vld_q, cmp_vld_d;  // rddata answers last cycle's read
    logic [DATA_W-1:0] exp_q, exp_d;          // expected word for that read
`endif

    // Pattern for address a; the address is zero-extended or truncated to the word width.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] fv);
        logic [DATA_W-1:0] ae;
        ae = DATA_W'(a);
        case (m)
            2'b00:   pattern = ae;
            2'b01:   pattern = fv;
            2'b10:   pattern = ~ae;
            default: pattern = ae ^ fv;
        endcase
    endfunction

    assign cur_past_hi = cur_q > {1'b0, hi_q};

    // Next-state and registered-output computation for the fill/verify sequencer.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        hi_d     = hi_q;
        fv_d     = fv_q;
        cur_d    = cur_q;
        rdy_d    = rdy_q;
        wren_d   = 1'b0;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
`ifdef MEM_FILL_VERIFY_EN
        lo_d      = lo_q;
        rd_pend_d = 1'b0;
        cmp_vld_d = rd_pend_q;
        exp_d     = rd_pend_q ? pattern(mode_q, addr_q, fv_q) : exp_q;
        err_d     = err_q | (cmp_vld_q && (rddata != exp_q));
`endif
        case (state_q)
            S_IDLE: begin
                rdy_d = 1'b1;
                if (en) begin
                    mode_d  = mode;
                    hi_d    = hi_addr;
                    fv_d    = fill_val;
                    cur_d   = {1'b0, lo_addr};
                    rdy_d   = 1'b0;
                    state_d = S_WRITE;
`ifdef MEM_FILL_VERIFY_EN
                    lo_d  = lo_addr;
                    err_d = 1'b0;
`endif
                end
            end
            S_WRITE: begin
                // An empty range (lo > hi) lands here with the cursor already past hi.
                if (cur_past_hi) begin
`ifdef MEM_FILL_VERIFY_EN
                    if (lo_q <= hi_q) begin
                        state_d   = S_READ;
                        addr_d    = lo_q;
                        cur_d     = {1'b0, lo_q} + CUR_ONE;
                        rd_pend_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b1;
                    end
`else
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
`endif
                end else begin
                    wren_d   = 1'b1;
                    addr_d   = cur_q[ADDR_W-1:0];
                    wrdata_d = pattern(mode_q, cur_q[ADDR_W-1:0], fv_q);
                    cur_d    = cur_q + CUR_ONE;
                end
            end
`ifdef MEM_FILL_VERIFY_EN
            S_READ: begin
                if (cur_past_hi) begin
                    state_d = S_CHECK;
                end else begin
                    addr_d    = cur_q[ADDR_W-1:0];
                    cur_d     = cur_q + CUR_ONE;
                    rd_pend_d = 1'b1;
                end
            end
            S_CHECK: begin
                // Last compare happens this cycle; err lands on the same edge rdy rises.
                state_d = S_IDLE;
                rdy_d   = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset aborts any job on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'b00;
            hi_q     <= '0;
            fv_q     <= '0;
            cur_q    <= '0;
            rdy_q    <= 1'b1;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
`ifdef MEM_FILL_VERIFY_EN
            lo_q      <= '0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            cmp_vld_q <= 1'b0;
            exp_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            hi_q     <= hi_d;
            fv_q     <= fv_d;
            cur_q    <= cur_d;
            rdy_q    <= rdy_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
`ifdef MEM_FILL_VERIFY_EN
            lo_q      <= lo_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
            cmp_vld_q <= cmp_vld_d;
            exp_q     <= exp_d;
`endif
        end
    end

    assign rdy    = rdy_q;
    assign wren   = wren_q;
    assign addr   = addr_q;
    assign wrdata = wrdata_q;

`ifdef MEM_FILL_VERIFY_EN
    assign err = err_q;
`else
    logic unused_rddata;
    assign unused_rddata = ^rddata;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fill.sv
// Self-checking bench for mem_fill with a behavioural RAM and pattern reference.
module tb_mem_fill;

`ifdef MEM_FILL_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       rdy;
    logic [1:0] mode = 2'b00;
    logic [7:0] lo_addr = 8'd0;
    logic [7:0] hi_addr = 8'd0;
    logic [7:0] fill_val = 8'd0;
    logic [7:0] addr;
    logic [7:0] wrdata;
    logic       wren;
    logic [7:0] rddata = 8'd0;
    logic       err;

    int vectors = 0;
    int miscmp = 0;
    int corrupt_addr = -1;
    logic [7:0] mem [256];

    mem_fill #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .mode(mode),
        .lo_addr(lo_addr), .hi_addr(hi_addr), .fill_val(fill_val),
        .addr(addr), .wrdata(wrdata), .wren(wren), .rddata(rddata), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: registered read, optional single-address read corruption.
    always @(posedge clk) begin
        if (wren) mem[addr] <= wrdata;
        rddata <= mem[addr] ^ ((int'(addr) == corrupt_addr) ? 8'h01 : 8'h00);
    end

    // Reference pattern straight from the rule table.
    function automatic int ref_f(input int m, input int a, input int fv);
        int a8;
        a8 = a % 256;
        case (m)
            0:       return a8;
            1:       return fv;
            2:       return 255 - a8;
            default: return a8 ^ fv;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscmp++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one job and check every cycle until rdy returns.
    task automatic run_job(input int m, input int lo, input int hi, input int fv,
                           input bit noise, input bit exp_err);
        int n;
        mode = 2'(m); lo_addr = 8'(lo); hi_addr = 8'(hi); fill_val = 8'(fv);
        en = 1'b1;
        step();
        en = 1'b0;
        chk("accept_rdy", rdy, 0);
        chk("accept_wren", wren, 0);
        chk("accept_err", err, 0);
        n = (lo <= hi) ? hi - lo + 1 : 0;
        for (int k = 1; k <= n; k++) begin
            step();
            chk("wr_wren", wren, 1);
            chk("wr_addr", addr, lo + k - 1);
            chk("wr_data", wrdata, ref_f(m, lo + k - 1, fv));
            chk("wr_rdy", rdy, 0);
            if (noise && k < n) begin
                en = 1'($urandom);
                mode = 2'($urandom); lo_addr = 8'($urandom);
                hi_addr = 8'($urandom); fill_val = 8'($urandom);
            end else begin
                en = 1'b0;
            end
        end
        en = 1'b0;
        if (VER && n > 0) begin
            for (int k = 1; k <= n; k++) begin
                step();
                chk("rd_wren", wren, 0);
                chk("rd_addr", addr, lo + k - 1);
                chk("rd_rdy", rdy, 0);
            end
            step();
            chk("chk_rdy", rdy, 0);
        end
        step();
        chk("done_rdy", rdy, 1);
        chk("done_wren", wren, 0);
        chk("done_err", err, exp_err);
    endtask

    initial begin
        int lo, hi;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rdy", rdy, 1);
        chk("rst_wren", wren, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_err", err, 0);

        // Full identity range; done cycle also proves there is no wrap write to 0.
        run_job(0, 0, 255, 0, 1'b0, 1'b0);
        // xor A5 over 16..19.
        run_job(3, 16, 19, 'hA5, 1'b0, 1'b0);
        // Empty range.
        run_job(0, 10, 9, 0, 1'b0, 1'b0);
        // en and input noise during a 100-word fill must not disturb it.
        run_job(2, 50, 149, 'h33, 1'b1, 1'b0);

        // Reset during cycle T50 of a full fill.
        mode = 2'b00; lo_addr = 8'd0; hi_addr = 8'd255; en = 1'b1;
        step();
        en = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            chk("pre_rst_addr", addr, k - 1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_rdy", rdy, 1);
        step();
        chk("post_rst_wren", wren, 0);
        run_job(1, 200, 203, 'h5A, 1'b0, 1'b0);

        // Corrupted read of address 5: err only when verify is built; next job clears it.
        corrupt_addr = 5;
        run_job(1, 0, 7, 'h3C, 1'b0, VER);
        corrupt_addr = -1;
        run_job(1, 0, 7, 'h3C, 1'b0, 1'b0);

        // Randomized jobs, some empty, some with busy-time noise.
        for (int j = 0; j < 12; j++) begin
            lo = int'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) hi = (lo > 0) ? lo - 1 : 255;
            else hi = (lo + int'($urandom_range(0, 20)) > 255) ? 255 : lo + int'($urandom_range(0, 20));
            run_job(int'($urandom_range(0, 3)), lo, hi, int'($urandom_range(0, 255)),
                    1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
